moonbase_nbus_master: RTL and testbench

- Parametrised bus-interface unit for the moonbase tiny-pin CPUs. It serialises one memory or IO request per transaction onto a narrow strobed pin bus: address slices first, an optional IO-intro beat, then data nibbles.
- Generalises the fixed 12-bit / 6-bit / 4-bit beat scheme of the current PDP-8 core in three ways: configurable widths, external wait states on a `bus_wait` pin, and a wait timeout.
- Sits between a CPU core's request/response interface and the top-level `io_in`/`io_out` pins.

---
 rtl/moonbase_nbus_master.sv | 172 +++++++++++++++++
 tb/tb_moonbase_nbus_master.sv | 133 +++++++++++++
 2 files changed

// File: rtl/moonbase_nbus_master.sv
// moonbase_nbus_master: serialises one memory/IO request per transaction onto a narrow strobed pin bus
// Address slices, optional IO-intro beat, then data nibbles; bus_wait stretches IO/data beats with a timeout.
module moonbase_nbus_master #(
   parameter int ADDR_W   = 12,
   parameter int DATA_W   = 12,
   parameter int NIB_W    = 4,
   parameter int ABEAT_W  = 6,
   parameter int IOC_W    = 3,
   parameter int MAX_WAIT = 15
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [ADDR_W-1:0]    req_addr,
   input  logic [DATA_W-1:0]    req_wdata,
   input  logic                 req_write,
   input  logic                 req_io,
   input  logic [IOC_W-1:0]     req_ioc,
   output logic                 rsp_valid,
   output logic [DATA_W-1:0]    rsp_rdata,
   output logic                 rsp_io_ready,
   output logic                 rsp_io_skip,
   output logic                 rsp_err,
   output logic [ABEAT_W+1:0]   bus_out,
   input  logic [NIB_W-1:0]     bus_in,
   input  logic                 bus_wait
);
   localparam int NA = (ADDR_W + ABEAT_W - 1) / ABEAT_W;
   localparam int ND = (DATA_W + NIB_W - 1) / NIB_W;
   localparam int AW = NA * ABEAT_W;
   localparam int DW = ND * NIB_W;
   localparam int BW = ABEAT_W + 2;
   localparam int CW = $clog2((NA > ND ? NA : ND) + 1);
   localparam int WW = $clog2(MAX_WAIT + 1) + 1;

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_IOB, S_DATA} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WW-1:0]      wait_q, wait_d;
   logic [AW-1:0]      addr_q, addr_d;
   logic [DW-1:0]      wdat_q, wdat_d, rbuf_q, rbuf_d;
   logic               write_q, write_d, io_q, io_d, io_rdy_q, io_rdy_d, io_skp_q, io_skp_d;
   logic [IOC_W-1:0]   ioc_q, ioc_d;
   logic [BW-1:0]      bus_out_q, bus_out_d;
   logic               rsp_valid_q, rsp_valid_d, rsp_io_ready_q, rsp_io_ready_d;
   logic               rsp_io_skip_q, rsp_io_skip_d, rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
   logic               waited, tmo;

   assign waited = (state_q == S_IOB || state_q == S_DATA) && bus_wait;
   assign wait_d = waited ? wait_q + 1'b1 : '0;
   assign tmo    = MAX_WAIT > 0 && waited && wait_d == WW'(MAX_WAIT);

   // Address and write data are shifted so the outgoing slice/nibble is always the top field
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      addr_d         = addr_q;
      wdat_d         = wdat_q;
      rbuf_d         = rbuf_q;
      write_d        = write_q;
      io_d           = io_q;
      ioc_d          = ioc_q;
      io_rdy_d       = io_rdy_q;
      io_skp_d       = io_skp_q;
      rsp_valid_d    = 1'b0;
      rsp_rdata_d    = rsp_rdata_q;
      rsp_io_ready_d = rsp_io_ready_q;
      rsp_io_skip_d  = rsp_io_skip_q;
      rsp_err_d      = rsp_err_q;
      case (state_q)
         S_IDLE: if (req_valid) begin
            state_d  = S_ADDR;
            cnt_d    = '0;
            addr_d   = AW'(req_addr);
            wdat_d   = DW'(req_wdata);
            rbuf_d   = '0;
            write_d  = req_write;
            io_d     = req_io;
            ioc_d    = req_ioc;
            io_rdy_d = 1'b0;
            io_skp_d = 1'b0;
         end
         S_ADDR: begin
            addr_d  = addr_q << ABEAT_W;
            cnt_d   = (cnt_q == CW'(NA - 1)) ? '0 : cnt_q + 1'b1;
            state_d = (cnt_q == CW'(NA - 1)) ? (io_q ? S_IOB : S_DATA) : S_ADDR;
         end
         S_IOB: if (!bus_wait) begin
            io_rdy_d = bus_in[0];
            io_skp_d = bus_in[1];
            state_d  = S_DATA;
         end
         default: if (!bus_wait) begin
            rbuf_d = (rbuf_q << NIB_W) | DW'(bus_in);
            wdat_d = wdat_q << NIB_W;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CW'(ND - 1)) begin
               state_d        = S_IDLE;
               rsp_valid_d    = 1'b1;
               rsp_rdata_d    = write_q ? '0 : rbuf_d[DATA_W-1:0];
               rsp_io_ready_d = io_rdy_q;
               rsp_io_skip_d  = io_skp_q;
               rsp_err_d      = 1'b0;
            end
         end
      endcase
      if (tmo) begin
         state_d        = S_IDLE;
         rsp_valid_d    = 1'b1;
         rsp_err_d      = 1'b1;
         rsp_rdata_d    = '0;
         rsp_io_ready_d = 1'b0;
         rsp_io_skip_d  = 1'b0;
      end
      bus_out_d = state_d == S_ADDR ? (BW'({1'b1, cnt_d == CW'(NA - 1)}) << ABEAT_W) | BW'(addr_d[AW-1 -: ABEAT_W])
                : state_d == S_IOB  ? (BW'(2'b10) << NIB_W) | BW'(ioc_d)
                : state_d == S_DATA ? (BW'(cnt_d == CW'(ND - 1)) << (BW - 2)) | (BW'(write_d) << NIB_W)
                                      | (write_d ? BW'(wdat_d[DW-1 -: NIB_W]) : '0)
                : BW'(2'b11) << NIB_W;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         wait_q         <= '0;
         addr_q         <= '0;
         wdat_q         <= '0;
         rbuf_q         <= '0;
         write_q        <= 1'b0;
         io_q           <= 1'b0;
         ioc_q          <= '0;
         io_rdy_q       <= 1'b0;
         io_skp_q       <= 1'b0;
         bus_out_q      <= BW'(2'b11) << NIB_W;
         rsp_valid_q    <= 1'b0;
         rsp_rdata_q    <= '0;
         rsp_io_ready_q <= 1'b0;
         rsp_io_skip_q  <= 1'b0;
         rsp_err_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         wait_q         <= wait_d;
         addr_q         <= addr_d;
         wdat_q         <= wdat_d;
         rbuf_q         <= rbuf_d;
         write_q        <= write_d;
         io_q           <= io_d;
         ioc_q          <= ioc_d;
         io_rdy_q       <= io_rdy_d;
         io_skp_q       <= io_skp_d;
         bus_out_q      <= bus_out_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_rdata_q    <= rsp_rdata_d;
         rsp_io_ready_q <= rsp_io_ready_d;
         rsp_io_skip_q  <= rsp_io_skip_d;
         rsp_err_q      <= rsp_err_d;
      end
   end

   assign req_ready    = state_q == S_IDLE;
   assign bus_out      = bus_out_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_rdata    = rsp_rdata_q;
   assign rsp_io_ready = rsp_io_ready_q;
   assign rsp_io_skip  = rsp_io_skip_q;
   assign rsp_err      = rsp_err_q;
endmodule

// File: tb/tb_moonbase_nbus_master.sv
// tb_moonbase_nbus_master: scoreboard bench; per-cycle beat plan and expected responses queued at drive time
module tb_moonbase_nbus_master;
   localparam int MAXW = 15;

   logic        clk = 1'b0, reset = 1'b1;
   logic        req_valid = 1'b0, req_ready, req_write = 1'b0, req_io = 1'b0;
   logic [11:0] req_addr = '0, req_wdata = '0;
   logic [2:0]  req_ioc = '0;
   logic        rsp_valid, rsp_io_ready, rsp_io_skip, rsp_err;
   logic [11:0] rsp_rdata;
   logic [7:0]  bus_out;
   logic [3:0]  bus_in = '0;
   logic        bus_wait = 1'b0;

   typedef struct packed {logic [7:0] beat; logic [3:0] bin; logic w;} cyc_t;
   typedef struct packed {logic [11:0] rd; logic err; logic rdy; logic skp;} rsp_t;
   cyc_t cq[$];
   rsp_t rq[$];
   int total = 0, bad = 0;

   always #5 clk = ~clk;

   moonbase_nbus_master #(.ADDR_W(12), .DATA_W(12), .NIB_W(4), .ABEAT_W(6), .IOC_W(3), .MAX_WAIT(MAXW)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_write(req_write), .req_io(req_io), .req_ioc(req_ioc),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_io_ready(rsp_io_ready), .rsp_io_skip(rsp_io_skip),
      .rsp_err(rsp_err), .bus_out(bus_out), .bus_in(bus_in), .bus_wait(bus_wait)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] dbeat(input int k, input logic wr, input logic [11:0] wd);
      logic [3:0] nib;
      nib = wr ? wd[11-4*k -: 4] : 4'h0;
      return {1'b0, k == 2, 1'b0, wr, nib};
   endfunction

   // wb: index of the stretched IOB/data beat (-1 none), wn: wait cycles on it (>= MAXW aborts)
   task automatic txn(input logic [11:0] a, input logic [11:0] wd, input logic wr, input logic io,
                      input logic [2:0] ioc, input logic [11:0] rd, input logic [1:0] st,
                      input int wb, input int wn);
      int nb;
      bit stop;
      cyc_t e;
      rsp_t r;
      nb = io ? 4 : 3;
      stop = 0;
      cq.push_back('{{2'b10, a[11:6]}, 4'($urandom), 1'($urandom)});
      cq.push_back('{{2'b11, a[5:0]}, 4'($urandom), 1'($urandom)});
      for (int i = 0; i < nb && !stop; i++) begin
         int k;
         logic [7:0] b;
         logic [3:0] v;
         k = io ? i - 1 : i;
         b = (io && i == 0) ? {5'b00100, ioc} : dbeat(k, wr, wd);
         v = (io && i == 0) ? {2'b00, st} : (wr ? 4'($urandom) : rd[11-4*k -: 4]);
         if (i == wb) for (int j = 0; j < wn && j < MAXW; j++) cq.push_back('{b, 4'($urandom), 1'b1});
         if (i == wb && wn >= MAXW) stop = 1;
         else cq.push_back('{b, v, 1'b0});
      end
      rq.push_back(stop ? rsp_t'{12'h0, 1'b1, 1'b0, 1'b0} : rsp_t'{wr ? 12'h0 : rd, 1'b0, io & st[0], io & st[1]});
      chk("ready", req_ready, 1);
      req_valid = 1'b1; req_addr = a; req_wdata = wd; req_write = wr; req_io = io; req_ioc = ioc;
      @(posedge clk); #1;
      req_valid = 1'b0; req_addr = 12'($urandom); req_wdata = 12'($urandom);
      req_write = 1'($urandom); req_io = 1'($urandom); req_ioc = 3'($urandom);
      for (int c = 0; cq.size() > 0; c++) begin
         e = cq.pop_front();
         bus_in = e.bin;
         bus_wait = e.w;
         chk($sformatf("beat%0d a=%h", c, a), {rsp_valid, bus_out}, {1'b0, e.beat});
         @(posedge clk); #1;
      end
      bus_wait = 1'b0;
      r = rq.pop_front();
      chk("rsp_cycle", {rsp_valid, req_ready, bus_out}, {1'b1, 1'b1, 8'h30});
      chk("rdata", rsp_rdata, r.rd);
      chk("err", rsp_err, r.err);
      chk("io_flags", {rsp_io_ready, rsp_io_skip}, {r.rdy, r.skp});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_ready", req_ready, 1);
      chk("rst_rsp", {rsp_valid, rsp_rdata, rsp_io_ready, rsp_io_skip, rsp_err}, 0);
      chk("rst_bus", bus_out, 8'h30);
      txn(12'o1234, 12'h000, 0, 0, 3'd0, 12'h5A3, 2'b00, -1, 0);
      txn(12'o0000, 12'hABC, 1, 0, 3'd0, 12'h000, 2'b00, -1, 0);
      txn(12'o0043, 12'h000, 0, 1, 3'd5, 12'h1F0, 2'b11, -1, 0);
      @(posedge clk); #1;
      chk("hold", {rsp_valid, rsp_rdata, rsp_io_ready, rsp_io_skip}, {1'b0, 12'h1F0, 1'b1, 1'b1});
      txn(12'o1234, 12'h000, 0, 0, 3'd0, 12'h5A3, 2'b00, 1, 3);
      txn(12'o1234, 12'h000, 0, 0, 3'd0, 12'h777, 2'b00, 0, MAXW);
      txn(12'o7001, 12'h000, 0, 1, 3'd2, 12'h0C3, 2'b01, 0, 4);
      txn(12'o4321, 12'h9E7, 1, 1, 3'd7, 12'h000, 2'b10, 3, MAXW - 1);
      txn(12'o5555, 12'h000, 0, 1, 3'd1, 12'h246, 2'b10, 1, MAXW);
      for (int n = 0; n < 8; n++)
         txn(12'($urandom), 12'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), 12'($urandom),
             2'($urandom), $urandom_range(0, 4), $urandom_range(0, 5));
      req_valid = 1'b1; req_addr = 12'o7777; req_write = 1'b0; req_io = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("rst_a0", bus_out, 8'hBF);
      @(posedge clk); #1;
      chk("rst_a1", bus_out, 8'hFF);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rst_mid", {rsp_valid, req_ready, bus_out, rsp_rdata}, {1'b0, 1'b1, 8'h30, 12'h0});
      for (int c = 0; c < 6; c++) begin
         chk("rst_norsp", {rsp_valid, bus_out}, {1'b0, 8'h30});
         @(posedge clk); #1;
      end
      txn(12'o0707, 12'h000, 0, 0, 3'd0, 12'h3C5, 2'b00, -1, 0);
      txn(12'o7070, 12'h000, 0, 0, 3'd0, 12'hA5A, 2'b00, -1, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
